cursor_report_scheduler: RTL

//  Sequences the 3-byte cursor UART transmitter: accumulates signed motion deltas and

---
 rtl/cursor_pkg.sv | 42 ++++
 rtl/cursor_axis_acc.sv | 55 +++++
 rtl/cursor_report_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor report path: FSM states, packet timing
// and the saturation helpers used by the per-axis accumulators.
package cursor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // One packet is three 10-bit UART frames plus an idle guard gap.
    function automatic int packet_clks(input int clks_per_bit, input int guard_clks);
        return 30 * clks_per_bit + guard_clks;
    endfunction

    // Clip to the symmetric payload range; -128 is never produced.
    function automatic logic signed [7:0] clip8(input logic signed [31:0] v);
        if (v > 32'sd127) begin
            return 8'sd127;
        end else if (v < -32'sd127) begin
            return -8'sd127;
        end else begin
            return v[7:0];
        end
    endfunction

    // Clip to the signed range of a w-bit accumulator (w <= 31).
    function automatic logic signed [31:0] clip_acc(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/cursor_axis_acc.sv
// One motion axis: accumulates signed deltas with saturation, captures the
// 8-bit payload when a report is scheduled and subtracts it on the send
// cycle so the residual (plus any same-cycle delta) carries forward.
module cursor_axis_acc
    import cursor_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             delta_valid,
    input  logic [IN_W-1:0]  delta,
    input  logic             load,
    input  logic             send,
    output logic [7:0]       payload,
    output logic [ACC_W-1:0] acc,
    output logic             sat
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [7:0]       payload_q, payload_d;
    logic signed [IN_W-1:0]  delta_s;
    logic signed [31:0]      acc_ext, delta_add, pay_sub, raw_c, clip_c;

    assign delta_s   = delta;
    assign acc_ext   = 32'(acc_q);
    assign delta_add = delta_valid ? 32'(delta_s) : 32'sd0;
    assign pay_sub   = send ? 32'(payload_q) : 32'sd0;

    // Next accumulator value: add delta, remove the sent payload, saturate.
    always_comb begin
        raw_c     = acc_ext + delta_add - pay_sub;
        clip_c    = clip_acc(raw_c, ACC_W);
        sat       = enable && (clip_c != raw_c);
        acc_d     = enable ? clip_c[ACC_W-1:0] : '0;
        payload_d = load ? clip8(acc_ext) : payload_q;
    end

    // Accumulator and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            payload_q <= '0;
        end else begin
            acc_q     <= acc_d;
            payload_q <= payload_d;
        end
    end

    assign payload = payload_q;
    assign acc     = acc_q;

endmodule

// File: rtl/cursor_report_scheduler.sv
// Decides when a 3-byte cursor report goes to the UART transmitter, issues a
// single send strobe per packet and times the packet locally so no strobe is
// ever issued while a frame is still on the wire.
module cursor_report_scheduler
    import cursor_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int REPORT_CLKS  = 1000000,
    parameter int GUARD_CLKS   = 1736,
    parameter int IN_W         = 12,
    parameter int ACC_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            delta_valid,
    input  logic [IN_W-1:0] delta_x,
    input  logic [IN_W-1:0] delta_y,
    input  logic            left_in,
    input  logic            right_in,
    output logic            send_strobe,
    output logic [7:0]      dx,
    output logic [7:0]      dy,
    output logic            left_click,
    output logic            right_click,
    output logic            busy,
    output logic            sat_flag
);

    localparam int PACKET_CLKS = packet_clks(CLKS_PER_BIT, GUARD_CLKS);
    localparam int HOLD_W      = $clog2(PACKET_CLKS + 1);
    localparam int TMR_W       = $clog2(REPORT_CLKS + 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [1:0]          last_clk_q, last_clk_d;
    logic                left_q, left_d, right_q, right_d;
    logic                sat_q, sat_d;
    logic                load, send, due, click_chg, acc_nz;
    logic                sat_x, sat_y;
    logic [ACC_W-1:0]    acc_x, acc_y;

    cursor_axis_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_x (
        .clk(clk), .rst_n(rst_n), .enable(enable), .delta_valid(delta_valid),
        .delta(delta_x), .load(load), .send(send),
        .payload(dx), .acc(acc_x), .sat(sat_x)
    );

    cursor_axis_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_y (
        .clk(clk), .rst_n(rst_n), .enable(enable), .delta_valid(delta_valid),
        .delta(delta_y), .load(load), .send(send),
        .payload(dy), .acc(acc_y), .sat(sat_y)
    );

    assign send      = (state_q == ST_SEND);
    assign due       = (timer_q == TMR_W'(REPORT_CLKS - 1));
    assign acc_nz    = (acc_x != '0) || (acc_y != '0);
    assign click_chg = ({left_in, right_in} != last_clk_q);

    // Next-state logic: schedule, strobe, then hold off for one packet time.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        load       = 1'b0;
        last_clk_d = last_clk_q;
        left_d     = left_q;
        right_d    = right_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && (click_chg || (due && acc_nz))) begin
                    state_d = ST_SEND;
                    load    = 1'b1;
                    left_d  = left_in;
                    right_d = right_in;
                end
            end
            ST_SEND: begin
                last_clk_d = {left_q, right_q};
                hold_d     = HOLD_W'(PACKET_CLKS - 1);
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Report interval timer: held at zero while disabled, restarts on each send.
    always_comb begin
        timer_d = timer_q;
        if (!enable || send) begin
            timer_d = '0;
        end else if (!due) begin
            timer_d = timer_q + TMR_W'(1);
        end
        sat_d = sat_q | sat_x | sat_y;
    end

    // State, timer, click and sticky saturation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            timer_q    <= '0;
            last_clk_q <= '0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            timer_q    <= timer_d;
            last_clk_q <= last_clk_d;
            left_q     <= left_d;
            right_q    <= right_d;
            sat_q      <= sat_d;
        end
    end

    assign send_strobe = send;
    assign busy        = (state_q == ST_SEND) || (state_q == ST_HOLD);
    assign left_click  = left_q;
    assign right_click = right_q;
    assign sat_flag    = sat_q;

endmodule
